// File: rtl/tiny86_step_sequencer.sv
// Feeds 560-bit trace steps to the tiny86 step-checking core and enforces regfile chaining
// between consecutive steps. Optional WAIT timeout is enabled by defining TINY86_SEQ_TIMEOUT_EN.
module tiny86_step_sequencer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_steps,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic [559:0]     step_data,
    output logic [559:0]     core_step,
    output logic             core_req,
    input  logic             core_done,
    input  logic [319:0]     core_regs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_step,
    output logic [1:0]       fail_code
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   fail_step_q, fail_step_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic [319:0]       expect_q, expect_d;
    logic [559:0]       core_step_q, core_step_d;
    logic               step_ready_q, step_ready_d;
    logic               core_req_q, core_req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               xfer_s;
    logic               chain_bad_s;
    logic [CNT_W-1:0]   count_inc_s;

`ifdef TINY86_SEQ_TIMEOUT_EN
    localparam int WT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [WT_W-1:0]    wait_inc_s;
`else
    logic               unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
`endif

    assign xfer_s      = step_valid & step_ready_q;
    assign count_inc_s = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    // Step 0 has no predecessor, so only later steps are chain-checked.
    assign chain_bad_s = (count_q != {CNT_W{1'b0}}) && (step_data[463:144] != expect_q);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        num_d       = num_q;
        fail_step_d = fail_step_q;
        fail_code_d = fail_code_q;
        expect_d    = expect_q;
        core_step_d = core_step_q;
`ifdef TINY86_SEQ_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        wait_inc_s  = wait_cnt_q + {{(WT_W-1){1'b0}}, 1'b1};
`endif
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    num_d       = num_steps;
                    count_d     = {CNT_W{1'b0}};
                    fail_step_d = {CNT_W{1'b0}};
                    fail_code_d = 2'd0;
                    if (num_steps == {CNT_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                if (xfer_s && chain_bad_s) begin
                    state_d     = S_FAIL;
                    fail_code_d = 2'd1;
                    fail_step_d = count_q;
                end else if (xfer_s) begin
                    core_step_d = step_data;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef TINY86_SEQ_TIMEOUT_EN
                wait_cnt_d = {WT_W{1'b0}};
`endif
            end
            S_WAIT: begin
                if (core_done) begin
                    expect_d = core_regs;
                    count_d  = count_inc_s;
                    if (count_inc_s == num_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
`ifdef TINY86_SEQ_TIMEOUT_EN
                end else if (wait_inc_s == WT_W'(TIMEOUT_CYCLES)) begin
                    state_d     = S_FAIL;
                    fail_code_d = 2'd2;
                    fail_step_d = count_q;
                end else begin
                    wait_cnt_d = wait_inc_s;
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered with it.
        step_ready_d = (state_d == S_FETCH);
        core_req_d   = (state_d == S_ISSUE);
        busy_d       = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_WAIT);
        done_d       = (state_d == S_DONE) || (state_d == S_FAIL);
        pass_d       = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= {CNT_W{1'b0}};
            num_q        <= {CNT_W{1'b0}};
            fail_step_q  <= {CNT_W{1'b0}};
            fail_code_q  <= 2'd0;
            expect_q     <= 320'd0;
            core_step_q  <= 560'd0;
            step_ready_q <= 1'b0;
            core_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef TINY86_SEQ_TIMEOUT_EN
            wait_cnt_q   <= {WT_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            num_q        <= num_d;
            fail_step_q  <= fail_step_d;
            fail_code_q  <= fail_code_d;
            expect_q     <= expect_d;
            core_step_q  <= core_step_d;
            step_ready_q <= step_ready_d;
            core_req_q   <= core_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
`ifdef TINY86_SEQ_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign step_ready = step_ready_q;
    assign core_step  = core_step_q;
    assign core_req   = core_req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_step  = fail_step_q;
    assign fail_code  = fail_code_q;

endmodule

// File: tb/tb_tiny86_step_sequencer.sv
// Directed bench for tiny86_step_sequencer: a cycle model of the sequencing rules is checked
// against the DUT every cycle, plus hand-computed expectations per scenario.
module tb_tiny86_step_sequencer;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   num_steps = 32'd0;
    logic          step_valid = 1'b0;
    logic          step_ready;
    logic [559:0]  step_data = 560'd0;
    logic [559:0]  core_step;
    logic          core_req;
    logic          core_done = 1'b0;
    logic [319:0]  core_regs = 320'd0;
    logic          busy, done, pass;
    logic [31:0]   fail_step;
    logic [1:0]    fail_code;

    tiny86_step_sequencer #(.CNT_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
        .step_valid(step_valid), .step_ready(step_ready), .step_data(step_data),
        .core_step(core_step), .core_req(core_req), .core_done(core_done),
        .core_regs(core_regs), .busy(busy), .done(done), .pass(pass),
        .fail_step(fail_step), .fail_code(fail_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [559:0] act, input logic [559:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [559:0] mk_step(input logic [319:0] r, input logic [7:0] tag);
        return {{12{tag}}, r, {18{tag}}};
    endfunction

    // ---------------- reference model: what the sequencer is doing this cycle ----------
    localparam int P_IDLE = 0, P_FETCH = 1, P_ISSUE = 2, P_WAIT = 3, P_DONE = 4, P_FAIL = 5;
    int            m_ph;
    logic [31:0]   m_cnt, m_n, m_fs;
    logic [1:0]    m_fc;
    logic [319:0]  m_exp;
    logic [559:0]  m_step;
    int            m_wt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= P_IDLE; m_cnt <= 32'd0; m_n <= 32'd0; m_fs <= 32'd0; m_fc <= 2'd0;
            m_exp <= 320'd0; m_step <= 560'd0; m_wt <= 0;
        end else if ((m_ph == P_IDLE || m_ph == P_DONE || m_ph == P_FAIL) && start) begin
            m_n <= num_steps; m_cnt <= 32'd0; m_fs <= 32'd0; m_fc <= 2'd0;
            m_ph <= (num_steps == 32'd0) ? P_DONE : P_FETCH;
        end else if (m_ph == P_FETCH && step_valid) begin
            if (m_cnt != 32'd0 && step_data[463:144] != m_exp) begin
                m_ph <= P_FAIL; m_fc <= 2'd1; m_fs <= m_cnt;
            end else begin
                m_step <= step_data; m_ph <= P_ISSUE;
            end
        end else if (m_ph == P_ISSUE) begin
            m_ph <= P_WAIT; m_wt <= 0;
        end else if (m_ph == P_WAIT && core_done) begin
            m_exp <= core_regs; m_cnt <= m_cnt + 32'd1;
            m_ph <= (m_cnt + 32'd1 == m_n) ? P_DONE : P_FETCH;
        end else if (m_ph == P_WAIT) begin
`ifdef TINY86_SEQ_TIMEOUT_EN
            if (m_wt + 1 == TO) begin
                m_ph <= P_FAIL; m_fc <= 2'd2; m_fs <= m_cnt;
            end else begin
                m_wt <= m_wt + 1;
            end
`endif
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("step_ready", step_ready, m_ph == P_FETCH);
            chk("core_req", core_req, m_ph == P_ISSUE);
            chk("busy", busy, m_ph == P_FETCH || m_ph == P_ISSUE || m_ph == P_WAIT);
            chk("done", done, m_ph == P_DONE || m_ph == P_FAIL);
            chk("pass", pass, m_ph == P_DONE);
            chk("fail_step", fail_step, m_fs);
            chk("fail_code", fail_code, m_fc);
            chk("core_step", core_step, m_step);
        end
    end

    // ---------------- monitors ----------------------------------------------------------
    int            req_cnt = 0, busy_cyc = 0, wait_cyc = 0;
    logic [559:0]  issued[$];
    always @(negedge clk) begin
        if (core_req) begin
            req_cnt++;
            issued.push_back(core_step);
        end
        if (busy) busy_cyc++;
        if (busy && !step_ready && !core_req) wait_cyc++;
    end

    // ---------------- trace source ------------------------------------------------------
    logic [559:0]  src_q[$];
    bit            toggle_mode = 1'b0;
    initial begin : producer
        bit took;
        bit ph;
        ph = 1'b1;
        forever begin
            @(negedge clk);
            took = step_valid && step_ready && rst_n;
            @(posedge clk);
            #2;
            if (took && src_q.size() > 0) void'(src_q.pop_front());
            ph = toggle_mode ? ~ph : 1'b1;
            step_valid = (src_q.size() > 0) && ph;
            step_data  = (src_q.size() > 0) ? src_q[0] : 560'd0;
        end
    end

    // ---------------- core responder: regs out = regs in + 1 ---------------------------
    bit            resp_en = 1'b1;
    bit            force_done = 1'b0;
    int            resp_delay = 1;
    initial begin : responder
        int pend;
        logic [319:0] rr;
        pend = 0;
        rr = 320'd0;
        forever begin
            @(posedge clk);
            #2;
            core_done = force_done;
            if (!rst_n) pend = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_done = 1'b1;
                    core_regs = rr;
                end
            end
            if (core_req && resp_en) begin
                pend = resp_delay;
                rr = core_step[463:144] + 320'd1;
            end
        end
    end

    // ---------------- helpers -----------------------------------------------------------
    task automatic start_trace(input logic [31:0] n);
        @(posedge clk);
        #2;
        req_cnt = 0; busy_cyc = 0; wait_cyc = 0;
        issued.delete();
        start = 1'b1;
        num_steps = n;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        if (k == budget) chk("wait_done_bound", 1'b0, 1'b1);
    endtask

    task automatic wait_req(input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            if (core_req) break;
            k++;
        end
        if (k == budget) chk("wait_req_bound", 1'b0, 1'b1);
    endtask

    // ---------------- directed scenarios ------------------------------------------------
    logic [319:0] r0;
    logic [319:0] r_bad;
    logic [559:0] sent[$];

    initial begin
        r0 = {32'h1, 288'h100};

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", step_ready, 1'b0);
        chk("rst_core_step", core_step, 560'd0);
        rst_n = 1'b1;

        // async reset in the middle of WAIT
        resp_en = 1'b0;
        src_q.push_back(mk_step(r0, 8'hA0));
        start_trace(32'd1);
        wait_req(20);
        @(posedge clk);
        #2;
        chk("wait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_core_step", core_step, 560'd0);
        chk("arst_outs", {step_ready, core_req, busy, done, pass}, 5'd0);
        chk("arst_fail", {fail_step, fail_code}, 34'd0);
        src_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        resp_en = 1'b1;

        // happy path: 3 chained steps, 1-cycle core latency
        resp_delay = 1;
        for (int i = 0; i < 3; i++) src_q.push_back(mk_step(r0 + 320'(i), 8'(8'h10 + i)));
        start_trace(32'd3);
        wait_done(100);
        chk("happy_reqs", req_cnt, 3);
        chk("happy_busy_cycles", busy_cyc, 9);
        chk("happy_pass", pass, 1'b1);
        chk("happy_code", fail_code, 2'd0);

        // chain break at step 2: eax 0x2 where the core produced 0x1
        src_q.delete();
        r_bad = r0 + 320'd2;
        r_bad[319:288] = 32'h2;
        src_q.push_back(mk_step(r0, 8'h20));
        src_q.push_back(mk_step(r0 + 320'd1, 8'h21));
        src_q.push_back(mk_step(r_bad, 8'h22));
        src_q.push_back(mk_step(r0 + 320'd3, 8'h23));
        start_trace(32'd4);
        wait_done(100);
        chk("break_pass", pass, 1'b0);
        chk("break_code", fail_code, 2'd1);
        chk("break_step", fail_step, 32'd2);
        chk("break_reqs", req_cnt, 2);

        // backpressure: valid toggles, core answers after 5 cycles
        src_q.delete();
        sent.delete();
        toggle_mode = 1'b1;
        resp_delay = 5;
        for (int i = 0; i < 3; i++) begin
            sent.push_back(mk_step(r0 + 320'(i), 8'(8'h30 + i)));
            src_q.push_back(mk_step(r0 + 320'(i), 8'(8'h30 + i)));
        end
        start_trace(32'd3);
        wait_done(200);
        chk("bp_pass", pass, 1'b1);
        chk("bp_count", issued.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < issued.size()) chk("bp_step", issued[i], sent[i]);
        end
        toggle_mode = 1'b0;

        // zero-length trace: verdict the cycle after start
        src_q.delete();
        start_trace(32'd0);
        #3;
        chk("zero_done", done, 1'b1);
        chk("zero_pass", pass, 1'b1);

        // spurious core_done in FETCH, start during WAIT
        resp_delay = 4;
        start_trace(32'd2);
        @(posedge clk);
        #2;
        force_done = 1'b1;
        @(posedge clk);
        #2;
        force_done = 1'b0;
        chk("spur_busy", busy, 1'b1);
        src_q.push_back(mk_step(r0, 8'h50));
        src_q.push_back(mk_step(r0 + 320'd1, 8'h51));
        wait_req(20);
        @(posedge clk);
        #2;
        start = 1'b1;
        num_steps = 32'd7;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(100);
        chk("spur_pass", pass, 1'b1);
        chk("spur_reqs", req_cnt, 2);

        // core never answers
        resp_en = 1'b0;
        src_q.delete();
        src_q.push_back(mk_step(r0, 8'h60));
        start_trace(32'd1);
`ifdef TINY86_SEQ_TIMEOUT_EN
        wait_done(100);
        chk("to_code", fail_code, 2'd2);
        chk("to_step", fail_step, 32'd0);
        chk("to_wait_cycles", wait_cyc, TO);
        chk("to_pass", pass, 1'b0);
`else
        repeat (40) @(negedge clk);
        chk("hold_busy", busy, 1'b1);
        chk("hold_done", done, 1'b0);
        chk("hold_code", fail_code, 2'd0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
